mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 15, wait-state cycles before a timeout abort; legal range 1-255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 rd_req  input  1  control-unit request: read memory at bus address into MDR.
REQ-005 wr_req  input  1  control-unit request: write bus data to memory at the address latched in MAR.
REQ-006 mem_ready  input  1  memory completion strobe.
REQ-007 MARin  output  1  MAR load enable.
REQ-008 MDRin  output  1  MDR load enable.
REQ-009 read  output  1  MDR input mux select: 1 = memory data, 0 = bus.
REQ-010 mem_rd  output  1  memory read strobe.
REQ-011 mem_wr  output  1  memory write strobe.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  one-cycle timeout pulse.
REQ-015 state  output  3  current state encoding, for debug.

Function
REQ-016 The block SHALL be a Moore FSM; outputs decode from state only: IDLE=0, MAR=1, RD_WAIT=2, RD_LATCH=3, WR_LOAD=4, WR_WAIT=5, DONE=6, ERR=7.
REQ-017 The block SHALL sample rd_req and wr_req only in IDLE and ignore them in all other states.
REQ-018 Read priority: with rd_req=wr_req=1 in IDLE, the block SHALL perform the read; the write request is dropped.
REQ-019 IDLE->MAR on either request; MAR asserts MARin for exactly one cycle, then goes to RD_WAIT (read op) or WR_LOAD (write op).
REQ-020 RD_WAIT: mem_rd=1, read=1; on mem_ready=1 -> RD_LATCH, else stay.
REQ-021 RD_LATCH: mem_rd=1, read=1, MDRin=1 for one cycle -> DONE.
REQ-022 WR_LOAD: read=0, MDRin=1 for one cycle (MDR captures bus data) -> WR_WAIT.
REQ-023 WR_WAIT: mem_wr=1, read=0; on mem_ready=1 -> DONE, else stay.
REQ-024 DONE: done=1 for one cycle -> IDLE; ERR: err=1 for one cycle -> IDLE.
REQ-025 mem_ready SHALL be ignored outside RD_WAIT and WR_WAIT.
REQ-026 Minimum latency (mem_ready held high): read done is high 4 cycles after the request-sampling edge; write done is high 4 cycles after it.
REQ-027 Outputs not listed for a state SHALL be 0 in that state.

Reset
REQ-028 On clr=0 the block SHALL enter IDLE asynchronously, clear the timeout counter, and drive every output to 0 (state=0).
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done or err pulse; after release the block SHALL wait in IDLE for a new request.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to RD_WAIT or WR_WAIT and increment each wait cycle; if it reaches TIMEOUT_CYCLES with mem_ready=0, the next state SHALL be ERR.
REQ-031 mem_ready=1 on the same cycle the limit is reached SHALL take priority, giving normal completion.
REQ-032 Without MEM_TIMEOUT_EN, the wait states SHALL wait indefinitely, no counter SHALL exist, and err SHALL be constant 0.

Verification
REQ-033 Read: clr released, rd_req=1 for one cycle, mem_ready=1 three cycles later -> MARin 1 cycle, mem_rd/read high in the wait state, MDRin+read in RD_LATCH, done pulse, busy=0 afterwards.
REQ-034 Write: wr_req=1, mem_ready held 1 -> MARin, then MDRin with read=0, mem_wr 1 cycle, done 4 cycles after the sampling edge.
REQ-035 Collision: rd_req=wr_req=1 in IDLE -> read sequence only; mem_wr stays 0 throughout.
REQ-036 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15): rd_req, mem_ready held 0 -> err pulse after 15 RD_WAIT cycles, done=0, return to IDLE; without the macro, still in RD_WAIT after 100 cycles.
REQ-037 Reset mid-op: clr=0 during WR_WAIT -> all outputs 0 immediately, state=0, no done pulse after release.
REQ-038 Noise: mem_ready pulsed in IDLE and MAR -> no state advance beyond the specified transitions.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: drives MAR/MDR load enables and memory strobes for
// single read/write transfers. Optional wait-state timeout under `MEM_TIMEOUT_EN`.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rd_req,
  input  logic       wr_req,
  input  logic       mem_ready,
  output logic       MARin,
  output logic       MDRin,
  output logic       read,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MAR      = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_RD_LATCH = 3'd3,
    S_WR_LOAD  = 3'd4,
    S_WR_WAIT  = 3'd5,
    S_DONE     = 3'd6,
    S_ERR      = 3'd7
  } state_e;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e state_q, state_d;
  logic   rd_op_q, rd_op_d;   // operation chosen in IDLE, consumed in MAR
  logic   tmo_hit;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // tmo_cnt_q counts completed wait cycles; this cycle is the last allowed one.
  assign tmo_hit = ((tmo_cnt_q + 8'd1) == TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_MAR || state_q == S_WR_LOAD) begin
      tmo_cnt_d = 8'd0;
    end else if (state_q == S_RD_WAIT || state_q == S_WR_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TMO_LIMIT;
`endif

  // NOTE: state flops use non-blocking assignments and reset asynchronously on clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      rd_op_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_op_q <= rd_op_d;
    end
  end

  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    rd_op_d = rd_op_q;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d = S_MAR;
          rd_op_d = 1'b1;
        end else if (wr_req) begin
          state_d = S_MAR;
          rd_op_d = 1'b0;
        end
      end
      S_MAR:      state_d = rd_op_q ? S_RD_WAIT : S_WR_LOAD;
      S_RD_WAIT: begin
        if (mem_ready)    state_d = S_RD_LATCH;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_RD_LATCH: state_d = S_DONE;
      S_WR_LOAD:  state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (mem_ready)    state_d = S_DONE;
        else if (tmo_hit) state_d = S_ERR;
      end
      S_DONE:     state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Moore decode: outputs depend on state_q only.
  always_comb begin
    MARin  = 1'b0;
    MDRin  = 1'b0;
    read   = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    unique case (state_q)
      S_MAR:      MARin = 1'b1;
      S_RD_WAIT: begin
        mem_rd = 1'b1;
        read   = 1'b1;
      end
      S_RD_LATCH: begin
        mem_rd = 1'b1;
        read   = 1'b1;
        MDRin  = 1'b1;
      end
      S_WR_LOAD:  MDRin  = 1'b1;
      S_WR_WAIT:  mem_wr = 1'b1;
      S_DONE:     done   = 1'b1;
`ifdef MEM_TIMEOUT_EN
      S_ERR:      err    = 1'b1;
`endif
      default: ;
    endcase
  end

  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed sequences with per-cycle output
// checks; done/err pulses are matched against a queue of expected completions.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       clr, rd_req, wr_req, mem_ready;
  logic       MARin, MDRin, read, mem_rd, mem_wr, busy, done, err;
  logic [2:0] state;

  mem_access_ctrl #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .clr(clr), .rd_req(rd_req), .wr_req(wr_req), .mem_ready(mem_ready),
    .MARin(MARin), .MDRin(MDRin), .read(read), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .busy(busy), .done(done), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_err;
    int unsigned due;
  } exp_t;
  exp_t sb_q[$];

  // {state, MARin, MDRin, read, mem_rd, mem_wr, busy, done, err}
  logic [10:0] obs;
  assign obs = {state, MARin, MDRin, read, mem_rd, mem_wr, busy, done, err};

  localparam logic [10:0] V_IDLE     = 11'b000_00000_0_00;
  localparam logic [10:0] V_MAR      = 11'b001_10000_1_00;
  localparam logic [10:0] V_RD_WAIT  = 11'b010_00110_1_00;
  localparam logic [10:0] V_RD_LATCH = 11'b011_01110_1_00;
  localparam logic [10:0] V_WR_LOAD  = 11'b100_01000_1_00;
  localparam logic [10:0] V_WR_WAIT  = 11'b101_00001_1_00;
  localparam logic [10:0] V_DONE     = 11'b110_00000_1_10;
  localparam logic [10:0] V_ERR      = 11'b111_00000_1_01;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic is_err, input int unsigned due);
    exp_t e;
    e.is_err = is_err;
    e.due    = due;
    sb_q.push_back(e);
  endtask

  // Monitor: every done/err pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done || err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_completion", {30'b0, done, err}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("completion_kind",  {31'b0, err}, {31'b0, e.is_err});
          check("completion_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    int unsigned s;
    clr = 1'b0; rd_req = 1'b0; wr_req = 1'b0; mem_ready = 1'b0;
    #2 check("reset_outputs", {21'b0, obs}, {21'b0, V_IDLE});
    #20 clr = 1'b1;
    tick(); check("idle_after_release", {21'b0, obs}, {21'b0, V_IDLE});

    // Read, mem_ready arrives three cycles after the request.
    rd_req = 1'b1;
    tick(); s = cyc; rd_req = 1'b0; push_exp(1'b0, s + 4);
    check("rd_mar", {21'b0, obs}, {21'b0, V_MAR});
    tick(); check("rd_wait0", {21'b0, obs}, {21'b0, V_RD_WAIT});
    tick(); check("rd_wait1", {21'b0, obs}, {21'b0, V_RD_WAIT});
    mem_ready = 1'b1;
    tick(); check("rd_latch", {21'b0, obs}, {21'b0, V_RD_LATCH});
    mem_ready = 1'b0;
    tick(); check("rd_done", {21'b0, obs}, {21'b0, V_DONE});
    tick(); check("rd_idle", {21'b0, obs}, {21'b0, V_IDLE});

    // Write at minimum latency: DONE occupies the 4th cycle after the sampling edge.
    wr_req = 1'b1; mem_ready = 1'b1;
    tick(); s = cyc; wr_req = 1'b0; push_exp(1'b0, s + 3);
    check("wr_mar", {21'b0, obs}, {21'b0, V_MAR});
    tick(); check("wr_load", {21'b0, obs}, {21'b0, V_WR_LOAD});
    tick(); check("wr_wait", {21'b0, obs}, {21'b0, V_WR_WAIT});
    tick(); check("wr_done", {21'b0, obs}, {21'b0, V_DONE});
    mem_ready = 1'b0;
    tick(); check("wr_idle", {21'b0, obs}, {21'b0, V_IDLE});

    // Collision: read wins, mem_wr never asserted.
    rd_req = 1'b1; wr_req = 1'b1; mem_ready = 1'b1;
    tick(); s = cyc; rd_req = 1'b0; wr_req = 1'b0; push_exp(1'b0, s + 3);
    check("col_mar", {21'b0, obs}, {21'b0, V_MAR});
    tick(); check("col_rd_wait", {21'b0, obs}, {21'b0, V_RD_WAIT});
    tick(); check("col_rd_latch", {21'b0, obs}, {21'b0, V_RD_LATCH});
    tick(); check("col_done", {21'b0, obs}, {21'b0, V_DONE});
    mem_ready = 1'b0;
    tick(); check("col_idle", {21'b0, obs}, {21'b0, V_IDLE});

    // Noise: mem_ready in IDLE and MAR must not advance the FSM.
    mem_ready = 1'b1;
    tick(); check("noise_idle0", {21'b0, obs}, {21'b0, V_IDLE});
    tick(); check("noise_idle1", {21'b0, obs}, {21'b0, V_IDLE});
    rd_req = 1'b1;
    tick(); s = cyc; rd_req = 1'b0; push_exp(1'b0, s + 3);
    check("noise_mar", {21'b0, obs}, {21'b0, V_MAR});
    tick(); check("noise_rd_wait", {21'b0, obs}, {21'b0, V_RD_WAIT});
    tick(); check("noise_rd_latch", {21'b0, obs}, {21'b0, V_RD_LATCH});
    tick(); check("noise_done", {21'b0, obs}, {21'b0, V_DONE});
    mem_ready = 1'b0;
    tick(); check("noise_idle2", {21'b0, obs}, {21'b0, V_IDLE});

`ifdef MEM_TIMEOUT_EN
    // Timeout: 15 RD_WAIT cycles then a single ERR cycle.
    rd_req = 1'b1;
    tick(); s = cyc; rd_req = 1'b0; push_exp(1'b1, s + 16);
    for (int i = 0; i < 15; i++) begin
      tick(); check("tmo_rd_wait", {21'b0, obs}, {21'b0, V_RD_WAIT});
    end
    tick(); check("tmo_err", {21'b0, obs}, {21'b0, V_ERR});
    tick(); check("tmo_idle", {21'b0, obs}, {21'b0, V_IDLE});

    // mem_ready on the limit cycle beats the timeout.
    rd_req = 1'b1;
    tick(); s = cyc; rd_req = 1'b0; push_exp(1'b0, s + 17);
    for (int i = 0; i < 14; i++) begin
      tick(); check("lim_rd_wait", {21'b0, obs}, {21'b0, V_RD_WAIT});
    end
    mem_ready = 1'b1;
    tick(); check("lim_last_wait", {21'b0, obs}, {21'b0, V_RD_WAIT});
    tick(); check("lim_rd_latch", {21'b0, obs}, {21'b0, V_RD_LATCH});
    mem_ready = 1'b0;
    tick(); check("lim_done", {21'b0, obs}, {21'b0, V_DONE});
    tick(); check("lim_idle", {21'b0, obs}, {21'b0, V_IDLE});
`else
    // No timeout: RD_WAIT holds for 100 cycles, err never pulses.
    rd_req = 1'b1;
    tick(); rd_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick(); check("notmo_rd_wait", {21'b0, obs}, {21'b0, V_RD_WAIT});
    end
    s = cyc; mem_ready = 1'b1; push_exp(1'b0, s + 2);
    tick(); check("notmo_rd_latch", {21'b0, obs}, {21'b0, V_RD_LATCH});
    mem_ready = 1'b0;
    tick(); check("notmo_done", {21'b0, obs}, {21'b0, V_DONE});
    tick(); check("notmo_idle", {21'b0, obs}, {21'b0, V_IDLE});
`endif

    // Reset during WR_WAIT: immediate abort, no done afterwards.
    wr_req = 1'b1;
    tick(); wr_req = 1'b0;
    check("rst_mar", {21'b0, obs}, {21'b0, V_MAR});
    tick(); check("rst_wr_load", {21'b0, obs}, {21'b0, V_WR_LOAD});
    tick(); check("rst_wr_wait0", {21'b0, obs}, {21'b0, V_WR_WAIT});
    tick(); check("rst_wr_wait1", {21'b0, obs}, {21'b0, V_WR_WAIT});
    #3 clr = 1'b0;
    #1 check("rst_async", {21'b0, obs}, {21'b0, V_IDLE});
    tick(); check("rst_held", {21'b0, obs}, {21'b0, V_IDLE});
    #2 clr = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check("rst_post_idle", {21'b0, obs}, {21'b0, V_IDLE});
    end
    mem_ready = 1'b0;
    tick();

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
